// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the AXI read/write address arbiters.
package axi_arb_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int WDOG_W          = 16;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: with both requesting, favour the one not granted last.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);
  assign any = |req;
  assign gnt = (&req) ? ~last : req[1];
endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-address arbiter with ownership held through the R burst
// and a watchdog on R inactivity.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic ARVALID_M0,
  input  logic ARVALID_M1,
  output logic ARREADY_M0,
  output logic ARREADY_M1,
  output logic ARVALID_S,
  input  logic ARREADY_S,
  input  logic RVALID_S,
  input  logic RREADY_S,
  input  logic RLAST_S,
  output logic GRANT,
  output logic BUSY,
  output logic TIMEOUT_ERR
);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYC - 1);

  arb_state_e        state;
  logic              last_gnt;
  logic              rr_gnt;
  logic              rr_any;
  logic [WDOG_W-1:0] wdog;
  logic              r_hs;
  logic              last_hs;
  logic              expire;

  arb_rr2 u_rr (
    .req  ({ARVALID_M1, ARVALID_M0}),
    .last (last_gnt),
    .gnt  (rr_gnt),
    .any  (rr_any)
  );

  assign r_hs    = RVALID_S & RREADY_S;
  assign last_hs = r_hs & RLAST_S;
  assign expire  = (wdog == WDOG_MAX) & ~r_hs;

  // Grants only from IDLE, so an RLAST handshake always leaves one idle bubble.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      GRANT       <= 1'b0;
      last_gnt    <= 1'b1;
      wdog        <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= 1'b0;
      case (state)
        S_IDLE: if (rr_any) begin
          GRANT    <= rr_gnt;
          last_gnt <= rr_gnt;
          state    <= S_ADDR;
        end
        S_ADDR: if (ARREADY_S) begin
          state <= S_DATA;
          wdog  <= '0;
        end
        S_DATA: begin
          if (last_hs) begin
            state <= S_IDLE;
          end else if (r_hs) begin
            wdog <= '0;
          end else if (expire) begin
            TIMEOUT_ERR <= 1'b1;
            state       <= S_IDLE;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY       = (state != S_IDLE);
  assign ARVALID_S  = (state == S_ADDR);
  assign ARREADY_M0 = ARVALID_S & ARREADY_S & ~GRANT;
  assign ARREADY_M1 = ARVALID_S & ARREADY_S &  GRANT;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_axi_read_arbiter;
  localparam int TO = 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0, ARREADY_S = 1'b0;
  logic RVALID_S = 1'b0, RREADY_S = 1'b0, RLAST_S = 1'b0;
  logic ARREADY_M0, ARREADY_M1, ARVALID_S, GRANT, BUSY, TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle / 1 address / 2 data; owner; preferred master; quiet cycles
  int ph = 0, own = 0, pref = 0, q = 0;
  bit mto = 1'b0;
  bit model_ok = 1'b0;
  bit at_neg = 1'b0;

  axi_read_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .ARVALID_M0  (ARVALID_M0),
    .ARVALID_M1  (ARVALID_M1),
    .ARREADY_M0  (ARREADY_M0),
    .ARREADY_M1  (ARREADY_M1),
    .ARVALID_S   (ARVALID_S),
    .ARREADY_S   (ARREADY_S),
    .RVALID_S    (RVALID_S),
    .RREADY_S    (RREADY_S),
    .RLAST_S     (RLAST_S),
    .GRANT       (GRANT),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m0, m1, ar, rv, rr, rl);
    ARVALID_M0 = m0; ARVALID_M1 = m1; ARREADY_S = ar;
    RVALID_S = rv; RREADY_S = rr; RLAST_S = rl;
  endtask

  task automatic look();
    @(negedge ACLK);
    at_neg = 1'b1;
  endtask

  task automatic cmp_model();
    chk("m_grant", GRANT, logic'(own == 1));
    chk("m_busy", BUSY, logic'(ph != 0));
    chk("m_arvalid_s", ARVALID_S, logic'(ph == 1));
    chk("m_arready_m0", ARREADY_M0, logic'(ph == 1 && ARREADY_S && own == 0));
    chk("m_arready_m1", ARREADY_M1, logic'(ph == 1 && ARREADY_S && own == 1));
    chk("m_timeout", TIMEOUT_ERR, logic'(mto));
  endtask

  // advance the model by one clock using the inputs present this cycle
  task automatic model_adv();
    if (!ARESETn) begin
      ph = 0; own = 0; pref = 0; q = 0; mto = 1'b0; model_ok = 1'b1;
    end else begin
      mto = 1'b0;
      if (ph == 0) begin
        if (ARVALID_M0 || ARVALID_M1) begin
          own  = (ARVALID_M0 && ARVALID_M1) ? pref : (ARVALID_M1 ? 1 : 0);
          pref = 1 - own;
          ph   = 1;
        end
      end else if (ph == 1) begin
        if (ARREADY_S) begin ph = 2; q = 0; end
      end else begin
        if (RVALID_S && RREADY_S && RLAST_S) ph = 0;
        else if (RVALID_S && RREADY_S) q = 0;
        else if (q == TO - 1) begin mto = 1'b1; ph = 0; end
        else q++;
      end
    end
  endtask

  task automatic step();
    if (!at_neg) @(negedge ACLK);
    at_neg = 1'b0;
    if (model_ok) cmp_model();
    model_adv();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    // reset
    drive(0, 0, 0, 0, 0, 0);
    ARESETn = 1'b0;
    step(); step();
    ARESETn = 1'b1;

    // Scenario 1: both request, M0 first, 4-beat burst, then M1 after one bubble
    drive(1, 1, 0, 0, 0, 0);
    look();
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_grant", GRANT, 1'b0);
    chk("rst_arvalid_s", ARVALID_S, 1'b0);
    chk("rst_timeout", TIMEOUT_ERR, 1'b0);
    step();
    drive(0, 1, 1, 0, 0, 0);
    look();
    chk("s1_arvalid_s", ARVALID_S, 1'b1);
    chk("s1_grant0", GRANT, 1'b0);
    chk("s1_arready_m0", ARREADY_M0, 1'b1);
    chk("s1_arready_m1", ARREADY_M1, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 1, logic'(i == 3));
      step();
    end
    drive(0, 1, 0, 0, 0, 0);
    look();
    chk("s1_bubble_busy", BUSY, 1'b0);
    chk("s1_bubble_grant", GRANT, 1'b0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    look();
    chk("s1_grant1", GRANT, 1'b1);
    chk("s1_arvalid_s2", ARVALID_S, 1'b1);
    step();
    drive(0, 0, 0, 1, 1, 1); step();

    // Scenario 2: M1 alone, slave stalls AR for 5 cycles
    drive(0, 1, 0, 0, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      look();
      chk("s2_arvalid_s", ARVALID_S, 1'b1);
      chk("s2_arready_m1", ARREADY_M1, 1'b0);
      chk("s2_grant", GRANT, 1'b1);
      step();
    end
    drive(0, 1, 1, 0, 0, 0);
    look();
    chk("s2_arready_m1_hs", ARREADY_M1, 1'b1);
    step();
    drive(0, 0, 0, 1, 1, 1); step();

    // Scenario 3: M1 requests during M0 data phase
    drive(1, 0, 0, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, logic'(i == 2));
      look();
      chk("s3_arready_m1", ARREADY_M1, 1'b0);
      step();
    end
    drive(0, 1, 0, 0, 0, 0);
    look();
    chk("s3_bubble", BUSY, 1'b0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    look();
    chk("s3_grant1", GRANT, 1'b1);
    step();
    drive(0, 0, 0, 1, 1, 1); step();

    // Scenario 4: M0 owns, no R beats -> watchdog expiry
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      look();
      chk("s4_no_early_to", TIMEOUT_ERR, 1'b0);
      chk("s4_busy", BUSY, 1'b1);
      step();
    end
    look();
    chk("s4_to_pulse", TIMEOUT_ERR, 1'b1);
    step();
    drive(1, 1, 0, 0, 0, 0);
    look();
    chk("s4_to_once", TIMEOUT_ERR, 1'b0);
    chk("s4_busy_after", BUSY, 1'b0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    look();
    chk("s4_prio_m1", GRANT, 1'b1);
    step();
    drive(0, 0, 0, 1, 1, 1); step();

    // RLAST handshake on the expiry cycle wins over the timeout
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step();
    drive(0, 0, 0, 1, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    look();
    chk("tie_no_to", TIMEOUT_ERR, 1'b0);
    chk("tie_idle", BUSY, 1'b0);
    step();

    // Scenario 5: reset during an M1 data phase
    drive(0, 1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    ARESETn = 1'b0; step();
    ARESETn = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    look();
    chk("s5_busy", BUSY, 1'b0);
    chk("s5_grant", GRANT, 1'b0);
    chk("s5_timeout", TIMEOUT_ERR, 1'b0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    look();
    chk("s5_grant_m0", GRANT, 1'b0);
    chk("s5_arvalid_s", ARVALID_S, 1'b1);
    step();
    drive(0, 0, 0, 1, 1, 1); step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ARESETn = ($urandom_range(0, 199) != 0);
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
